// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transceiver: FSM encodings, frame width
// and the baud divisor calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that marks one bit period; tick is high while the
// count sits at zero, and a load always wins over counting.
module uart_bit_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] count_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tick = (count_r == {W{1'b0}});

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART physical layer: edge-triggered transmitter and 2-flop-synchronised,
// mid-bit-sampling receiver running from a shared integer baud divisor.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 11059200,
  parameter int BAUD     = 115200
) (
  input  logic       uart_clk,
  input  logic       rst_bus,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LOAD_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] LOAD_HALF = CW'(DIV / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  uart_state_e tx_state_r, tx_state_s;
  logic        tx_start_q_r;
  logic        start_edge_s;
  logic [7:0]  tx_shift_r, tx_shift_s;
  logic [2:0]  tx_bit_r, tx_bit_s;
  logic        txd_r, txd_s;
  logic        tx_busy_r, tx_busy_s;
  logic        tx_load_s;
  logic        tx_tick_s;

  assign start_edge_s = tx_start & ~tx_start_q_r;

  uart_bit_timer #(.W(CW)) u_tx_timer (
    .clk      (uart_clk),
    .rst      (rst_bus),
    .load     (tx_load_s),
    .load_val (LOAD_FULL),
    .tick     (tx_tick_s)
  );

  // TX state, shift register and registered line outputs.
  always_ff @(posedge uart_clk or posedge rst_bus) begin
    if (rst_bus) begin
      tx_state_r   <= IDLE;
      tx_start_q_r <= 1'b0;
      tx_shift_r   <= 8'h00;
      tx_bit_r     <= 3'd0;
      txd_r        <= 1'b1;
      tx_busy_r    <= 1'b0;
    end else begin
      tx_state_r   <= tx_state_s;
      tx_start_q_r <= tx_start;
      tx_shift_r   <= tx_shift_s;
      tx_bit_r     <= tx_bit_s;
      txd_r        <= txd_s;
      tx_busy_r    <= tx_busy_s;
    end
  end

  // TX next-state: edges seen outside IDLE are consumed by the edge register and dropped.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_shift_s = tx_shift_r;
    tx_bit_s   = tx_bit_r;
    txd_s      = txd_r;
    tx_busy_s  = tx_busy_r;
    tx_load_s  = 1'b0;
    case (tx_state_r)
      IDLE: begin
        if (start_edge_s) begin
          tx_state_s = START;
          tx_shift_s = tx_data;
          tx_bit_s   = 3'd0;
          txd_s      = 1'b0;
          tx_busy_s  = 1'b1;
          tx_load_s  = 1'b1;
        end else begin
          txd_s      = 1'b1;
          tx_busy_s  = 1'b0;
        end
      end
      START: begin
        if (tx_tick_s) begin
          tx_state_s = DATA;
          txd_s      = tx_shift_r[0];
          tx_bit_s   = 3'd0;
          tx_load_s  = 1'b1;
        end else begin
          tx_load_s  = 1'b0;
        end
      end
      DATA: begin
        if (tx_tick_s) begin
          tx_load_s = 1'b1;
          if (tx_bit_r == LAST_BIT) begin
            tx_state_s = STOP;
            txd_s      = 1'b1;
          end else begin
            tx_shift_s = {1'b0, tx_shift_r[7:1]};
            txd_s      = tx_shift_r[1];
            tx_bit_s   = tx_bit_r + 3'd1;
          end
        end else begin
          tx_load_s = 1'b0;
        end
      end
      STOP: begin
        if (tx_tick_s) begin
          tx_state_s = IDLE;
          txd_s      = 1'b1;
          tx_busy_s  = 1'b0;
        end else begin
          tx_load_s  = 1'b0;
        end
      end
      default: begin
        tx_state_s = IDLE;
        txd_s      = 1'b1;
        tx_busy_s  = 1'b0;
      end
    endcase
  end

  assign txd     = txd_r;
  assign tx_busy = tx_busy_r;

  // ---------------- receiver ----------------
  uart_state_e rx_state_r, rx_state_s;
  logic        rxd_meta_r, rxd_sync_r;
  logic [7:0]  rx_shift_r, rx_shift_s;
  logic [2:0]  rx_bit_r, rx_bit_s;
  logic [7:0]  rx_data_r, rx_data_s;
  logic        rx_ready_r, rx_ready_s;
  logic        rx_err_r, rx_err_s;
  logic        rx_load_s;
  logic [CW-1:0] rx_load_val_s;
  logic        rx_tick_s;

  uart_bit_timer #(.W(CW)) u_rx_timer (
    .clk      (uart_clk),
    .rst      (rst_bus),
    .load     (rx_load_s),
    .load_val (rx_load_val_s),
    .tick     (rx_tick_s)
  );

  // rxd synchroniser, RX state and registered strobes.
  always_ff @(posedge uart_clk or posedge rst_bus) begin
    if (rst_bus) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rx_state_r <= IDLE;
      rx_shift_r <= 8'h00;
      rx_bit_r   <= 3'd0;
      rx_data_r  <= 8'h00;
      rx_ready_r <= 1'b0;
      rx_err_r   <= 1'b0;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
      rx_state_r <= rx_state_s;
      rx_shift_r <= rx_shift_s;
      rx_bit_r   <= rx_bit_s;
      rx_data_r  <= rx_data_s;
      rx_ready_r <= rx_ready_s;
      rx_err_r   <= rx_err_s;
    end
  end

  // RX next-state: returns to IDLE right after the mid-stop sample to catch back-to-back frames.
  always_comb begin
    rx_state_s    = rx_state_r;
    rx_shift_s    = rx_shift_r;
    rx_bit_s      = rx_bit_r;
    rx_data_s     = rx_data_r;
    rx_ready_s    = 1'b0;
    rx_err_s      = 1'b0;
    rx_load_s     = 1'b0;
    rx_load_val_s = LOAD_FULL;
    case (rx_state_r)
      IDLE: begin
        if (!rxd_sync_r) begin
          rx_state_s    = START;
          rx_load_s     = 1'b1;
          rx_load_val_s = LOAD_HALF;
        end else begin
          rx_state_s    = IDLE;
        end
      end
      START: begin
        if (rx_tick_s) begin
          if (rxd_sync_r) begin
            rx_state_s = IDLE;
          end else begin
            rx_state_s = DATA;
            rx_bit_s   = 3'd0;
            rx_load_s  = 1'b1;
          end
        end else begin
          rx_load_s = 1'b0;
        end
      end
      DATA: begin
        if (rx_tick_s) begin
          rx_shift_s = {rxd_sync_r, rx_shift_r[7:1]};
          rx_load_s  = 1'b1;
          if (rx_bit_r == LAST_BIT) begin
            rx_state_s = STOP;
          end else begin
            rx_bit_s   = rx_bit_r + 3'd1;
          end
        end else begin
          rx_load_s = 1'b0;
        end
      end
      STOP: begin
        if (rx_tick_s) begin
          rx_state_s = IDLE;
          if (rxd_sync_r) begin
            rx_data_s  = rx_shift_r;
            rx_ready_s = 1'b1;
          end else begin
            rx_err_s   = 1'b1;
          end
        end else begin
          rx_load_s = 1'b0;
        end
      end
      default: begin
        rx_state_s = IDLE;
      end
    endcase
  end

  assign rx_ready     = rx_ready_r;
  assign rx_data      = rx_data_r;
  assign rx_frame_err = rx_err_r;

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver at default parameters (96 clocks per bit).
module tb_uart_transceiver;

  localparam int DIV = 96;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_exp_t;

  logic       uart_clk = 1'b0;
  logic       rst_bus;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       txd;
  logic       rxd;
  logic       rxd_drv;
  logic       loop_en;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       busy_prev;

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  rx_exp_t    rxq[$];

  always #5 uart_clk = ~uart_clk;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_transceiver dut (
    .uart_clk     (uart_clk),
    .rst_bus      (rst_bus),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .txd          (txd),
    .rxd          (rxd),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tx_pulse(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge uart_clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge uart_clk);
      n++;
    end
    if (tx_busy) begin
      checks++;
      errors++;
      $display("FAIL tx_timeout got=busy want=idle");
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_ok);
    rxd_drv = 1'b0;
    repeat (DIV) @(negedge uart_clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (DIV) @(negedge uart_clk);
    end
    if (stop_ok) begin
      rxd_drv = 1'b1;
      repeat (DIV) @(negedge uart_clk);
    end else begin
      rxd_drv = 1'b0;
      repeat (60) @(negedge uart_clk);
      rxd_drv = 1'b1;
      repeat (DIV - 60) @(negedge uart_clk);
    end
  endtask

  // TX monitor: on each tx_busy rise, pop the expected byte and check every line cycle.
  initial begin
    logic [7:0] exp_b;
    logic       eb;
    int         bad;
    bit         aborted;
    busy_prev = 1'b0;
    forever begin
      @(negedge uart_clk);
      if (!rst_bus && tx_busy && !busy_prev) begin
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame got=frame want=none");
        end else begin
          exp_b   = txq.pop_front();
          bad     = 0;
          aborted = 1'b0;
          for (int k = 0; k < 10 * DIV; k++) begin
            if (k > 0) @(negedge uart_clk);
            if (rst_bus) begin
              aborted = 1'b1;
              break;
            end
            if (k / DIV == 0)      eb = 1'b0;
            else if (k / DIV == 9) eb = 1'b1;
            else                   eb = exp_b[k / DIV - 1];
            if (tx_busy !== 1'b1 || txd !== eb) bad++;
          end
          if (!aborted) begin
            check("tx_frame_bits", bad, 0);
            @(negedge uart_clk);
            check("tx_busy_len", {31'd0, tx_busy}, 32'd0);
          end
        end
      end
      busy_prev = tx_busy;
    end
  end

  // RX monitor: every strobe must match the head of the expected queue.
  always @(negedge uart_clk) begin
    rx_exp_t e;
    if (!rst_bus && (rx_ready || rx_frame_err)) begin
      if (rxq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_strobe got=rdy%0b err%0b data=%0h want=none", rx_ready, rx_frame_err, rx_data);
      end else begin
        e = rxq.pop_front();
        check("rx_strobe", {22'd0, rx_ready, rx_frame_err, rx_data},
              {22'd0, ~e.err, e.err, e.data});
      end
    end
  end

  initial begin
    rst_bus  = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    rxd_drv  = 1'b1;
    loop_en  = 1'b0;
    repeat (3) @(negedge uart_clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
    rst_bus = 1'b0;
    repeat (5) @(negedge uart_clk);

    // TX 0x55 with a one-cycle start pulse
    txq.push_back(8'h55);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge uart_clk);
    check("tx_first_cycle", {30'd0, tx_busy, txd}, {30'd0, 1'b1, 1'b0});
    tx_start = 1'b0;
    wait_tx_idle();
    repeat (20) @(negedge uart_clk);

    // start level held high: exactly one frame
    txq.push_back(8'hA3);
    tx_data  = 8'hA3;
    tx_start = 1'b1;
    repeat (2000) @(negedge uart_clk);
    check("tx_level_no_retrigger", {31'd0, tx_busy}, 32'd0);
    tx_start = 1'b0;
    repeat (20) @(negedge uart_clk);

    // RX good byte, then framing error, then short glitch
    rxq.push_back('{err: 1'b0, data: 8'hC4});
    send_rx(8'hC4, 1'b1);
    repeat (50) @(negedge uart_clk);
    rxq.push_back('{err: 1'b1, data: 8'hC4});
    send_rx(8'h12, 1'b0);
    repeat (200) @(negedge uart_clk);
    rxd_drv = 1'b0;
    repeat (20) @(negedge uart_clk);
    rxd_drv = 1'b1;
    repeat (200) @(negedge uart_clk);

    // loopback, each start issued as soon as tx_busy is seen low
    loop_en = 1'b1;
    repeat (5) @(negedge uart_clk);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h7E;
      wait_tx_idle();
      txq.push_back(b);
      rxq.push_back('{err: 1'b0, data: b});
      tx_pulse(b);
    end
    wait_tx_idle();
    repeat (200) @(negedge uart_clk);
    loop_en = 1'b0;
    repeat (20) @(negedge uart_clk);

    // reset in the middle of a TX frame and an RX frame
    txq.push_back(8'h3C);
    fork
      send_rx(8'h5A, 1'b1);
      begin
        tx_pulse(8'h3C);
        repeat (399) @(negedge uart_clk);
        rst_bus = 1'b1;
        #1;
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
      end
    join
    repeat (5) @(negedge uart_clk);
    rst_bus = 1'b0;
    repeat (5) @(negedge uart_clk);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);

    // full frames in both directions at once after reset
    txq.push_back(8'h96);
    rxq.push_back('{err: 1'b0, data: 8'h69});
    fork
      begin
        tx_pulse(8'h96);
        wait_tx_idle();
      end
      send_rx(8'h69, 1'b1);
    join
    repeat (300) @(negedge uart_clk);

    check("txq_drained", txq.size(), 0);
    check("rxq_drained", rxq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
